// File: rtl/softmax_stream.sv
`default_nettype none
// ============================================================================
// Module   : softmax_stream
// Purpose  : Streaming softmax over up to DEPTH chunks of N Q4.12 lanes;
//            buffers the vector, finds max, sums exp2 terms, takes log2 and
//            streams normalised probabilities back out.
// Options  : define SOFTMAX_STREAM_STATS_EN to expose stat_max / stat_log2sum.
// Revision : 1.0 - initial release
// ============================================================================
module softmax_stream #(
  parameter int N     = 4,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_last,
  input  logic [N-1:0]    in_mask,
  input  logic [N*16-1:0] in_x_flat,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic [N*16-1:0] prob_flat,
  output logic            err
`ifdef SOFTMAX_STREAM_STATS_EN
  ,
  output logic [15:0]     stat_max,
  output logic [19:0]     stat_log2sum
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = 13 + $clog2(N * DEPTH);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_load = 3'd1;
  localparam logic [2:0] c_st_sum  = 3'd2;
  localparam logic [2:0] c_st_log  = 3'd3;
  localparam logic [2:0] c_st_out  = 3'd4;

  // exp2((x - mx) * log2e - off), x <= mx assumed; result in Q.12, <= 0x1000
  function automatic logic [12:0] exp_term(input logic signed [15:0] x,
                                           input logic signed [15:0] mx,
                                           input logic signed [19:0] off);
    logic signed [21:0] d;
    logic signed [21:0] t;
    logic signed [21:0] te;
    logic signed [21:0] nk;
    d = $signed({{6{x[15]}}, x}) - $signed({{6{mx[15]}}, mx});
    if (d < -22'sd32768) d = -22'sd32768;
    if (d > 22'sd0)      d = 22'sd0;
    t  = d + (d >>> 1) - (d >>> 4);
    te = t - $signed({{2{off[19]}}, off});
    if (te > 22'sd0) te = 22'sd0;
    nk = -(te >>> 12);
    if (nk >= 22'sd13) exp_term = 13'd0;
    else               exp_term = {1'b1, te[11:0]} >> nk[3:0];
  endfunction

  logic [2:0]           state_q, state_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic signed [15:0]   max_q, max_d;
  logic [SW-1:0]        sum_q, sum_d;
  logic signed [19:0]   l_q, l_d;
  logic                 err_q, err_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [N*16-1:0]      prob_q, prob_d;
`ifdef SOFTMAX_STREAM_STATS_EN
  logic [15:0]          stat_max_q, stat_max_d;
  logic [19:0]          stat_l_q, stat_l_d;
`endif

  logic [N*16-1:0]      x_mem_q [DEPTH];
  logic [N-1:0]         m_mem_q [DEPTH];
  logic                 mem_we;
  logic [AW-1:0]        mem_waddr;

  logic [N*16-1:0]      rd_x;
  logic [N-1:0]         rd_m;
  logic signed [19:0]   off_w;
  logic [12:0]          e_w [N];
  logic [SW-1:0]        chunk_sum;
  logic [N*16-1:0]      prob_w;
  logic signed [15:0]   max_fold;
  int                   lz_p;
  logic [SW-1:0]        rem_w;
  logic [11:0]          frac_w;
  logic signed [19:0]   l_w;
  logic                 in_xfer;
  logic                 load_out;

  assign rd_x  = x_mem_q[rd_ptr_q[AW-1:0]];
  assign rd_m  = m_mem_q[rd_ptr_q[AW-1:0]];
  assign off_w = (state_q == c_st_out) ? l_q : 20'sd0;

  // One exp2 lane set serves both SUM (offset 0) and OUT (offset L)
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign e_w[i] = exp_term($signed(rd_x[i*16 +: 16]), max_q, off_w);
  end

  always_comb begin
    chunk_sum = '0;
    prob_w    = '0;
    for (int i = 0; i < N; i++) begin
      if (rd_m[i]) begin
        chunk_sum = chunk_sum + SW'(e_w[i]);
        prob_w[i*16 +: 16] = (e_w[i] > 13'h1000) ? 16'h1000 : {3'b000, e_w[i]};
      end
    end
  end

  always_comb begin
    max_fold = (state_q == c_st_idle) ? 16'sh8000 : max_q;
    for (int i = 0; i < N; i++) begin
      if (in_mask[i] && ($signed(in_x_flat[i*16 +: 16]) > max_fold)) begin
        max_fold = $signed(in_x_flat[i*16 +: 16]);
      end
    end
  end

  // Linear-mantissa log2: integer part from the leading one, fraction from the remainder
  always_comb begin
    lz_p = 0;
    for (int b = 0; b < SW; b++) begin
      if (sum_q[b]) lz_p = b;
    end
    rem_w = sum_q ^ (SW'(1) << lz_p);
    if (lz_p >= 12) frac_w = 12'(rem_w >> (lz_p - 12));
    else            frac_w = 12'(rem_w << (12 - lz_p));
    if (sum_q == '0) l_w = '0;
    else             l_w = 20'((lz_p - 12) * 4096 + int'(frac_w));
  end

  assign in_xfer  = in_valid && in_ready_q;
  assign load_out = (rd_ptr_q != cnt_q) && (!out_valid_q || out_ready);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    rd_ptr_d    = rd_ptr_q;
    max_d       = max_q;
    sum_d       = sum_q;
    l_d         = l_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    prob_d      = prob_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr_q;
`ifdef SOFTMAX_STREAM_STATS_EN
    stat_max_d  = stat_max_q;
    stat_l_d    = stat_l_q;
`endif
    case (state_q)
      c_st_idle: begin
        if (in_xfer) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          wr_ptr_d  = AW'(1);
          max_d     = max_fold;
          err_d     = 1'b0;
          sum_d     = '0;
          rd_ptr_d  = '0;
          cnt_d     = (AW+1)'(1);
          state_d   = in_last ? c_st_sum : c_st_load;
        end
      end
      c_st_load: begin
        if (in_xfer) begin
          mem_we   = 1'b1;
          max_d    = max_fold;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (in_last || (wr_ptr_q == AW'(DEPTH - 1))) begin
            cnt_d    = {1'b0, wr_ptr_q} + (AW+1)'(1);
            rd_ptr_d = '0;
            state_d  = c_st_sum;
            if (!in_last) err_d = 1'b1;
          end
        end
      end
      c_st_sum: begin
        sum_d = sum_q + chunk_sum;
        if (rd_ptr_q == cnt_q - (AW+1)'(1)) begin
          rd_ptr_d = '0;
          state_d  = c_st_log;
        end else begin
          rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
      end
      c_st_log: begin
        l_d     = l_w;
        state_d = c_st_out;
`ifdef SOFTMAX_STREAM_STATS_EN
        stat_max_d = max_q;
        stat_l_d   = l_w;
`endif
      end
      c_st_out: begin
        // One-deep output register refills on the same edge it is drained
        if (load_out) begin
          prob_d      = prob_w;
          out_valid_d = 1'b1;
          out_last_d  = (rd_ptr_q == cnt_q - (AW+1)'(1));
          rd_ptr_d    = rd_ptr_q + (AW+1)'(1);
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          prob_d      = '0;
          if (out_last_q) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            state_d  = c_st_idle;
          end
        end
      end
      default: state_d = c_st_idle;
    endcase
    in_ready_d = (state_d == c_st_idle) || (state_d == c_st_load);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= c_st_idle;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      max_q       <= 16'sh8000;
      sum_q       <= '0;
      l_q         <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      prob_q      <= '0;
`ifdef SOFTMAX_STREAM_STATS_EN
      stat_max_q  <= '0;
      stat_l_q    <= '0;
`endif
    end else if (en) begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      max_q       <= max_d;
      sum_q       <= sum_d;
      l_q         <= l_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      prob_q      <= prob_d;
`ifdef SOFTMAX_STREAM_STATS_EN
      stat_max_q  <= stat_max_d;
      stat_l_q    <= stat_l_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst && en && mem_we) begin
      x_mem_q[mem_waddr] <= in_x_flat;
      m_mem_q[mem_waddr] <= in_mask;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign prob_flat = prob_q;
  assign err       = err_q;
`ifdef SOFTMAX_STREAM_STATS_EN
  assign stat_max     = stat_max_q;
  assign stat_log2sum = stat_l_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_softmax_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_softmax_stream
// Purpose  : Vector table plus scoreboard bench for softmax_stream (N=4, DEPTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_softmax_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [3:0]  in_mask;
  logic [63:0] in_x_flat;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [63:0] prob_flat;
  logic        err;
`ifdef SOFTMAX_STREAM_STATS_EN
  logic [15:0] stat_max;
  logic [19:0] stat_log2sum;
`endif

  softmax_stream #(.N(4), .DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_mask   (in_mask),
    .in_x_flat (in_x_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .prob_flat (prob_flat),
    .err       (err)
`ifdef SOFTMAX_STREAM_STATS_EN
    ,
    .stat_max     (stat_max),
    .stat_log2sum (stat_log2sum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nch;
    bit          use_last;
    logic [3:0]  mask;
    logic [63:0] x;
    logic [63:0] prob;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [63:0] prob;
    logic        last;
    logic        err;
  } exp_t;

  vec_t tbl [8];
  exp_t sb_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Output side of the scoreboard: compare each accepted chunk
  always @(negedge clk) begin
    exp_t e;
    if (rst && en && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=%h required=none", prob_flat);
      end else begin
        e = sb_q.pop_front();
        chk("prob", prob_flat, e.prob);
        chk("out_last", {63'd0, out_last}, {63'd0, e.last});
        chk("err", {63'd0, err}, {63'd0, e.err});
      end
    end
  end

  task automatic send_vec(input vec_t v);
    bit ok;
    for (int c = 0; c < v.nch; c++) begin
      in_valid  = 1'b1;
      in_x_flat = v.x;
      in_mask   = v.mask;
      in_last   = v.use_last && (c == v.nch - 1);
      ok = 1'b0;
      for (int w = 0; w < 100; w++) begin
        @(negedge clk);
        if (in_ready && en) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL in_xfer_timeout actual=0 required=1");
      end
      @(posedge clk); #1;
      sb_q.push_back('{prob: v.prob, last: (c == v.nch - 1), err: v.err});
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input int drop_at, input int drop_len, output int lat);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (drop_len > 0 && lat == drop_at) en = 1'b0;
      if (drop_len > 0 && lat == drop_at + drop_len) en = 1'b1;
      if (out_valid) break;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", sb_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    tbl[0] = '{1,  1'b1, 4'hF, 64'h1000_1000_1000_1000, 64'h0400_0400_0400_0400, 1'b0};
    tbl[1] = '{2,  1'b1, 4'hF, 64'h0000_0000_0000_0000, 64'h0200_0200_0200_0200, 1'b0};
    tbl[2] = '{1,  1'b1, 4'h3, 64'h0000_0000_0000_0000, 64'h0000_0000_0800_0800, 1'b0};
    tbl[3] = '{1,  1'b1, 4'hF, 64'h0000_0000_0000_4000, 64'h004C_004C_004C_0F88, 1'b0};
    tbl[4] = '{1,  1'b1, 4'h3, 64'h7FFF_7FFF_0000_1000, 64'h0000_0000_04B0_0CE0, 1'b0};
    tbl[5] = '{1,  1'b1, 4'h0, 64'h1234_0000_8000_7FFF, 64'h0000_0000_0000_0000, 1'b0};
    tbl[6] = '{1,  1'b1, 4'hF, 64'h8000_8000_8000_8000, 64'h0400_0400_0400_0400, 1'b0};
    tbl[7] = '{16, 1'b0, 4'hF, 64'h0000_0000_0000_0000, 64'h0040_0040_0040_0040, 1'b1};

    rst = 1'b0; en = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    in_mask = '0; in_x_flat = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_last", {63'd0, out_last}, 64'd0);
    chk("rst_prob", prob_flat, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      send_vec(tbl[i]);
      wait_out(0, 0, lat);
      chk("latency", 64'(lat), 64'(tbl[i].nch + 2));
      drain();
    end

    // Backpressure: hold first chunk for 5 cycles, it must stay put
    out_ready = 1'b0;
    send_vec(tbl[1]);
    wait_out(0, 0, lat);
    chk("bp_latency", 64'(lat), 64'd4);
    for (int k = 0; k < 5; k++) begin
      chk("bp_prob_hold", prob_flat, tbl[1].prob);
      chk("bp_valid_hold", {63'd0, out_valid}, 64'd1);
      chk("bp_last_hold", {63'd0, out_last}, 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();

    // en low for 3 cycles during SUM stretches latency by 3
    send_vec(tbl[1]);
    wait_out(1, 3, lat);
    chk("en_latency", 64'(lat), 64'd7);
    drain();

    // Overflow vector, then reset while its output is stalled
    out_ready = 1'b0;
    send_vec(tbl[7]);
    wait_out(0, 0, lat);
    chk("ovf_latency", 64'(lat), 64'd18);
    chk("ovf_err", {63'd0, err}, 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_err", {63'd0, err}, 64'd0);
    chk("mid_rst_out_last", {63'd0, out_last}, 64'd0);
    chk("mid_rst_prob", prob_flat, 64'd0);
    sb_q.delete();
    out_ready = 1'b1;
    send_vec(tbl[3]);
    wait_out(0, 0, lat);
    chk("post_rst_latency", 64'(lat), 64'd3);
    drain();

    repeat (4) @(posedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/softmax_stream.md
Name: softmax_stream

Overview:
- Streaming softmax engine for vectors longer than the lane count, all values Q4.12.
- Accepts a vector as up to DEPTH chunks of N lanes over a valid/ready handshake and buffers it internally.
- Computes max, sum of exp2 terms and log2(sum) internally; no external max input is needed.
- Emits N-lane probability chunks under output backpressure. Successor to the fixed-N, single-shot softmax datapath.

Parameters:
- N, 4, lanes per chunk (≥1)
- DEPTH, 16, maximum chunks per vector (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (one clock; this polarity and synchronicity are fixed)
- en  in  1  global enable; when 0 all state, pointers and outputs hold
- in_valid  in  1  input chunk valid
- in_ready  out  1  block can accept a chunk
- in_last  in  1  chunk is the final chunk of the vector
- in_mask  in  N  lane i participates when 1
- in_x_flat  in  N*16  lane i at [i*16+:16], signed Q4.12
- out_valid  out  1  output chunk valid
- out_ready  in  1  consumer accepts
- out_last  out  1  final output chunk
- prob_flat  out  N*16  unsigned Q4.12 probabilities, ≤0x1000
- err  out  1  sticky overflow flag for the current vector

Behaviour:
- Reset (rst=0 at a clk edge with en=1, or regardless of en): state=IDLE, pointers=0, max=0x8000, sum=0. Outputs: in_ready=0, out_valid=0, out_last=0, prob_flat=0, err=0. Reset mid-vector discards the buffered vector.
- Handshakes:
  - A transfer occurs when valid&ready&en are all high at the clock edge.
  - out_valid/prob_flat/out_last stay stable until accepted.
  - in_ready=1 only in IDLE/LOAD.
- FSM, IDLE→LOAD→SUM→LOG→OUT→IDLE:
  - IDLE: in_ready=1. The first transfer stores chunk 0, clears err and enters LOAD, or SUM if in_last.
  - LOAD: stores chunk at wr_ptr and updates the running max over masked-in lanes. A transfer with in_last moves to SUM with C = chunks stored.
  - Overflow: a DEPTH-th transfer without in_last is treated as last and sets err=1.
  - All-masked vector: max stays 0x8000; every output lane is 0.
  - SUM: one stored chunk per cycle for C cycles, accumulating e_i over masked-in lanes.
    - d_i = x_i − max, saturated to ≥ −8.0.
    - t_i = d + (d>>>1) − (d>>>4), arithmetic shifts, ≈ d·log2e.
    - exp2(t) for t≤0: k=floor(t), f=t−k; result = (0x1000+f)>>(−k); result=0 if −k≥13.
    - Accumulator width 13+log2(N·DEPTH), never wraps.
  - LOG (1 cycle):
    - p = leading-one index of sum; L = ((p−12)<<12) + ((sum−2^p) scaled to 12 frac bits).
    - This is a linear-mantissa log2 in Q.12. If sum=0, L=0.
  - OUT:
    - Chunk j: prob_i = exp2(t_i − L) clipped to 0x1000; masked-out lane → 0.
    - Chunks leave in order 0..C−1; out_last=1 on chunk C−1; its transfer returns to IDLE.
    - in_ready=0 throughout OUT, so there is no overlap with the next vector.
- Latency: the first out_valid rises exactly C+2 enabled cycles after the in_last transfer edge, assuming no stall.
- Simultaneous events: en=0 freezes everything, including a pending transfer. An output held with out_ready=0 keeps all signals constant.

Optional Feature:
- Macro SOFTMAX_STREAM_STATS_EN.
- When defined, adds outputs stat_max (16, captured max) and stat_log2sum (20, L).
  - Both are valid from the end of LOG until the next vector's first transfer.
  - Both reset to 0.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Uniform: N=4, one chunk all 0x1000, in_last=1 → sum=0x4000, L=0x2000, all prob=0x0400. out_valid at edge+3, out_last=1.
- Two chunks, all 8 lanes 0x0000 → sum=0x8000, L=0x3000; both output chunks all 0x0200; out_last only on the 2nd.
- Mask: one chunk, mask=4'b0011, values 0x0000 → lanes0-1=0x0800, lanes2-3=0x0000.
- One-hot: lane0=0x4000, others 0 → other terms 0x0050, sum=0x10F0, L=0x00F0; prob = {0x0F88, 0x004C, 0x004C, 0x004C}.
- Backpressure/en:
  - Hold out_ready=0 for 5 cycles → prob_flat stable, chunk not skipped.
  - en=0 for 3 cycles mid-SUM → latency extended by exactly 3.
- Overflow/reset:
  - DEPTH=16 chunks without in_last → err=1, 16 output chunks.
  - rst=0 during OUT → next cycle IDLE, out_valid=0, err=0, a new vector processes correctly.
